// File: rtl/cluster_demux_bus_responder.sv
// Target end of the cluster demux bus: word-addressed flop memory, ordered
// response FIFO with r_gnt backpressure, and a two-state atomic RMW engine.
module cluster_demux_bus_responder #(
   parameter int unsigned MEM_WORDS       = 256,
   parameter int unsigned RESP_FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        barrier,
   input  logic        exec_cancel,
   input  logic        exec_stall,
   input  logic        req,
   input  logic [31:0] add,
   input  logic        we,
   input  logic [5:0]  atop,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        gnt,
   output logic        busy,
   output logic        r_valid,
   output logic [31:0] r_rdata,
   input  logic        r_gnt
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned PW = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RESP_FIFO_DEPTH + 1);

   typedef enum logic {IDLE, AMO} state_t;

   state_t        state;
   logic [31:0]   mem  [MEM_WORDS];
   logic [31:0]   fifo [RESP_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [AW-1:0] idx, amo_idx;
   logic [31:0]   amo_old, amo_opnd, amo_result, rd_word, push_data;
   logic [3:0]    amo_op;
   logic          accept, push, pop, is_atomic, amo_known;
   logic          unused_bits;

   // Address aliasing: only the word index inside the memory is decoded.
   assign idx         = add[AW+1:2];
   assign unused_bits = ^{add[1:0], add[31:AW+2], atop[4]};

   assign rd_word   = mem[idx];
   assign is_atomic = atop[5];
   assign amo_known = (atop[3:0] <= 4'd8);
   assign push_data = (!is_atomic && we) ? 32'h0 : rd_word;

   assign r_valid = (count != '0);
   assign r_rdata = r_valid ? fifo[rd_ptr] : 32'h0;
   assign busy    = r_valid | (state == AMO);

   // Slot check uses the pre-pop count, so a same-cycle pop never frees a slot.
   assign accept = req & ~exec_cancel & ~exec_stall & (state == IDLE)
                 & (count < CW'(RESP_FIFO_DEPTH)) & ~(barrier & busy);
   assign gnt    = accept;
   assign push   = accept;
   assign pop    = r_valid & r_gnt;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(RESP_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      amo_result = amo_old;
      case (amo_op)
         4'd0: amo_result = amo_opnd;
         4'd1: amo_result = amo_old + amo_opnd;
         4'd2: amo_result = amo_old & amo_opnd;
         4'd3: amo_result = amo_old | amo_opnd;
         4'd4: amo_result = amo_old ^ amo_opnd;
         4'd5: amo_result = ($signed(amo_old) > $signed(amo_opnd)) ? amo_old : amo_opnd;
         4'd6: amo_result = (amo_old > amo_opnd) ? amo_old : amo_opnd;
         4'd7: amo_result = ($signed(amo_old) < $signed(amo_opnd)) ? amo_old : amo_opnd;
         4'd8: amo_result = (amo_old < amo_opnd) ? amo_old : amo_opnd;
         default: amo_result = amo_old;
      endcase
   end

   // Storage (not reset); writes are suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == AMO) begin
            mem[amo_idx] <= amo_result;
         end else if (accept && !is_atomic && we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      if (push) fifo[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         amo_idx  <= '0;
         amo_old  <= '0;
         amo_opnd <= '0;
         amo_op   <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         case (state)
            IDLE: begin
               if (accept && is_atomic && amo_known) begin
                  amo_idx  <= idx;
                  amo_old  <= rd_word;
                  amo_opnd <= wdata;
                  amo_op   <= atop[3:0];
                  state    <= AMO;
               end
            end
            AMO:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
